// File: rtl/fcmp_sched_if.sv
// Bundle of the requester-side handshake and the compare-unit bus for fcmp_sched.
// The scheduler uses the slave view; a requester/compare-unit model uses the master view.
interface fcmp_sched_if #(
   parameter int N_REQ = 4
);
   logic [N_REQ-1:0]    req_valid;
   logic [N_REQ-1:0]    req_ready;
   logic [32*N_REQ-1:0] req_a;
   logic [32*N_REQ-1:0] req_b;
   logic [2*N_REQ-1:0]  req_op;
   logic [N_REQ-1:0]    resp_valid;
   logic [31:0]         resp_data;
   logic [31:0]         cmp_a;
   logic [31:0]         cmp_b;
   logic [1:0]          cmp_op;
   logic                cmp_en;
   logic [31:0]         cmp_c;
   logic                cmp_ready;
   logic                busy;
   logic                err;

   modport slave (
      input  req_valid, req_a, req_b, req_op, cmp_c, cmp_ready,
      output req_ready, resp_valid, resp_data, cmp_a, cmp_b, cmp_op, cmp_en, busy, err
   );

   modport master (
      output req_valid, req_a, req_b, req_op, cmp_c, cmp_ready,
      input  req_ready, resp_valid, resp_data, cmp_a, cmp_b, cmp_op, cmp_en, busy, err
   );
endinterface

// File: rtl/fcmp_sched.sv
// Round-robin scheduler sharing one 1-cycle FP compare unit among N_REQ requesters.
// Grants one request per cycle, issues it to the unit from registers, tracks its
// tag through two stages and routes the unit's result back as a one-hot pulse.
module fcmp_sched #(
   parameter int N_REQ = 4,
   parameter int IDW   = 2
) (
   input  logic         clk,
   input  logic         rstn,
   fcmp_sched_if.slave  bus
);

   logic [IDW-1:0]   ptr_r;
   logic [IDW-1:0]   ptr_next_s;
   logic [IDW-1:0]   gidx_s;
   logic [IDW-1:0]   cand_s;
   logic             any_s;
   logic [N_REQ-1:0] grant_s;
   int               sum_s;

   logic [31:0]      sel_a_s;
   logic [31:0]      sel_b_s;
   logic [1:0]       sel_op_s;

   logic [31:0]      cmp_a_r;
   logic [31:0]      cmp_b_r;
   logic [1:0]       cmp_op_r;
   logic             cmp_en_r;
   logic             v1_r;
   logic             v2_r;
   logic [IDW-1:0]   tag1_r;
   logic [IDW-1:0]   tag2_r;
   logic [N_REQ-1:0] resp_valid_r;
   logic [31:0]      resp_data_r;
   logic             busy_r;
   logic             err_r;

   function automatic logic [N_REQ-1:0] onehot(input logic [IDW-1:0] id);
      onehot = {{(N_REQ-1){1'b0}}, 1'b1} << id;
   endfunction

   // Round-robin search: first valid requester at or after ptr, wrapping at N_REQ.
   always_comb begin
      any_s  = 1'b0;
      gidx_s = '0;
      sum_s  = 0;
      cand_s = '0;
      for (int k = 0; k < N_REQ; k++) begin
         sum_s  = int'(ptr_r) + k;
         sum_s  = (sum_s >= N_REQ) ? (sum_s - N_REQ) : sum_s;
         cand_s = IDW'(sum_s);
         gidx_s = (!any_s && bus.req_valid[cand_s]) ? cand_s : gidx_s;
         any_s  = any_s | bus.req_valid[cand_s];
      end
      grant_s    = any_s ? onehot(gidx_s) : '0;
      ptr_next_s = (gidx_s == IDW'(N_REQ - 1)) ? '0 : (gidx_s + IDW'(1));
   end

   // Operand/opcode mux selecting the granted requester's slices.
   always_comb begin
      sel_a_s  = '0;
      sel_b_s  = '0;
      sel_op_s = '0;
      for (int k = 0; k < N_REQ; k++) begin
         sel_a_s  = (gidx_s == IDW'(k)) ? bus.req_a[k*32 +: 32] : sel_a_s;
         sel_b_s  = (gidx_s == IDW'(k)) ? bus.req_b[k*32 +: 32] : sel_b_s;
         sel_op_s = (gidx_s == IDW'(k)) ? bus.req_op[k*2 +: 2]  : sel_op_s;
      end
   end

   // Issue stage: advance pointer, register operands and tag for the granted op.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ptr_r    <= '0;
         cmp_a_r  <= '0;
         cmp_b_r  <= '0;
         cmp_op_r <= '0;
         cmp_en_r <= 1'b0;
         v1_r     <= 1'b0;
         tag1_r   <= '0;
      end else begin
         if (any_s) begin
            ptr_r    <= ptr_next_s;
            cmp_a_r  <= sel_a_s;
            cmp_b_r  <= sel_b_s;
            cmp_op_r <= sel_op_s;
         end else begin
            ptr_r    <= ptr_r;
            cmp_a_r  <= cmp_a_r;
            cmp_b_r  <= cmp_b_r;
            cmp_op_r <= cmp_op_r;
         end
         cmp_en_r <= any_s;
         v1_r     <= any_s;
         tag1_r   <= gidx_s;
      end
   end

   // Result stage: carry the tag one more cycle, then route the unit's result.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         v2_r         <= 1'b0;
         tag2_r       <= '0;
         busy_r       <= 1'b0;
         resp_valid_r <= '0;
         resp_data_r  <= '0;
      end else begin
         v2_r   <= v1_r;
         tag2_r <= tag1_r;
         busy_r <= any_s | v1_r;
         if (v2_r && bus.cmp_ready) begin
            resp_valid_r <= onehot(tag2_r);
            resp_data_r  <= bus.cmp_c;
         end else begin
            resp_valid_r <= '0;
            resp_data_r  <= resp_data_r;
         end
      end
   end

   // Sticky error: a result without an op in S2, or an op in S2 without a result.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         err_r <= 1'b0;
      end else if (v2_r != bus.cmp_ready) begin
         err_r <= 1'b1;
      end else begin
         err_r <= err_r;
      end
   end

   assign bus.req_ready  = grant_s & {N_REQ{rstn}};
   assign bus.cmp_a      = cmp_a_r;
   assign bus.cmp_b      = cmp_b_r;
   assign bus.cmp_op     = cmp_op_r;
   assign bus.cmp_en     = cmp_en_r;
   assign bus.resp_valid = resp_valid_r;
   assign bus.resp_data  = resp_data_r;
   assign bus.busy       = busy_r;
   assign bus.err        = err_r;

endmodule

// File: tb/tb_fcmp_sched.sv
// Directed bench for fcmp_sched: a compare-unit model answers cmp_en one cycle
// later, and a scoreboard of expected responses is filled at grant time.
module tb_fcmp_sched;
   localparam int N_REQ = 4;
   localparam int IDW   = 2;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   fcmp_sched_if #(.N_REQ(N_REQ)) bus ();

   fcmp_sched #(.N_REQ(N_REQ), .IDW(IDW)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   typedef struct {
      int          due;
      logic [3:0]  mask;
      logic [31:0] data;
      bit          lost;
   } exp_t;

   exp_t        sb[$];
   exp_t        ent;
   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   logic        pend_en = 1'b0;
   logic [31:0] pend_c = 32'd0;
   int          withhold_cyc = -1;
   bit          spur = 1'b0;
   bit          lose_next = 1'b0;
   logic [31:0] a_arr[4];
   logic [31:0] b_arr[4];
   logic [1:0]  op_arr[4];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Behaviour of the shared compare unit (positive, non-NaN operands only).
   function automatic logic [31:0] unit_res(input logic [31:0] a, input logic [31:0] b,
                                             input logic [1:0] op);
      case (op)
         2'b00:   return {31'd0, a == b};
         2'b01:   return {31'd0, a < b};
         2'b10:   return {31'd0, a <= b};
         default: return {a[15:0], b[15:0]};
      endcase
   endfunction

   task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] op);
      a_arr[i] = a; b_arr[i] = b; op_arr[i] = op;
      bus.req_a[32*i +: 32] = a;
      bus.req_b[32*i +: 32] = b;
      bus.req_op[2*i +: 2]  = op;
   endtask

   task automatic apply_model();
      bus.cmp_ready = (pend_en && (cyc != withhold_cyc)) || spur;
      bus.cmp_c     = pend_c;
      pend_en       = bus.cmp_en;
      pend_c        = unit_res(bus.cmp_a, bus.cmp_b, bus.cmp_op);
      spur          = 1'b0;
   endtask

   task automatic cycle(input logic [3:0] valid, input logic [3:0] exp_ready, input string tag);
      bus.req_valid = valid;
      #1;
      check({tag, " req_ready"}, {28'd0, bus.req_ready}, {28'd0, exp_ready});
      for (int i = 0; i < 4; i++) begin
         if (exp_ready[i]) begin
            ent.due  = cyc + 3;
            ent.mask = 4'b0001 << i;
            ent.data = unit_res(a_arr[i], b_arr[i], op_arr[i]);
            ent.lost = lose_next;
            if (lose_next) withhold_cyc = cyc + 2;
            lose_next = 1'b0;
            sb.push_back(ent);
         end
      end
      @(posedge clk);
      cyc++;
      #1;
      apply_model();
      if (sb.size() > 0 && sb[0].due == cyc) begin
         ent = sb.pop_front();
         if (ent.lost) begin
            check({tag, " lost resp_valid"}, {28'd0, bus.resp_valid}, 32'd0);
         end else begin
            check({tag, " resp_valid"}, {28'd0, bus.resp_valid}, {28'd0, ent.mask});
            check({tag, " resp_data"}, bus.resp_data, ent.data);
         end
      end else begin
         check({tag, " no resp"}, {28'd0, bus.resp_valid}, 32'd0);
      end
   endtask

   task automatic do_reset(input bit chk);
      rstn = 1'b0;
      sb.delete();
      pend_en = 1'b0; pend_c = 32'd0; withhold_cyc = -1; spur = 1'b0;
      bus.req_valid = 4'b1111;
      bus.cmp_ready = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      if (chk) begin
         check("rst req_ready", {28'd0, bus.req_ready}, 32'd0);
         check("rst resp_valid", {28'd0, bus.resp_valid}, 32'd0);
         check("rst resp_data", bus.resp_data, 32'd0);
         check("rst cmp_a", bus.cmp_a, 32'd0);
         check("rst cmp_b", bus.cmp_b, 32'd0);
         check("rst cmp_op", {30'd0, bus.cmp_op}, 32'd0);
         check("rst cmp_en", {31'd0, bus.cmp_en}, 32'd0);
         check("rst busy", {31'd0, bus.busy}, 32'd0);
         check("rst err", {31'd0, bus.err}, 32'd0);
      end
      bus.req_valid = 4'b0000;
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      cyc++;
      #1;
      apply_model();
   endtask

   initial begin
      bus.req_valid = 4'b0000;
      bus.req_a = '0; bus.req_b = '0; bus.req_op = '0;
      bus.cmp_c = 32'd0; bus.cmp_ready = 1'b0;
      for (int i = 0; i < 4; i++) set_req(i, 32'd0, 32'd0, 2'b00);

      do_reset(1'b1);

      // Round-robin fairness with all four requesters asserting.
      set_req(0, 32'h3F800000, 32'h40000000, 2'b01);
      set_req(1, 32'h40400000, 32'h40000000, 2'b10);
      set_req(2, 32'h41000000, 32'h41000000, 2'b00);
      set_req(3, 32'h12345678, 32'h9ABCDEF0, 2'b11);
      for (int r = 0; r < 2; r++) begin
         cycle(4'b1111, 4'b0001, "rr g0");
         cycle(4'b1111, 4'b0010, "rr g1");
         cycle(4'b1111, 4'b0100, "rr g2");
         cycle(4'b1111, 4'b1000, "rr g3");
      end
      for (int i = 0; i < 3; i++) cycle(4'b0000, 4'b0000, "rr drain");

      // Single op from requester 0: 1.0 <= 2.0.
      set_req(0, 32'h3F800000, 32'h40000000, 2'b10);
      cycle(4'b0001, 4'b0001, "single");
      check("single cmp_en", {31'd0, bus.cmp_en}, 32'd1);
      check("single cmp_a", bus.cmp_a, 32'h3F800000);
      check("single cmp_b", bus.cmp_b, 32'h40000000);
      check("single cmp_op", {30'd0, bus.cmp_op}, 32'd2);
      check("single busy S1", {31'd0, bus.busy}, 32'd1);
      cycle(4'b0000, 4'b0000, "single s2");
      check("single busy S2", {31'd0, bus.busy}, 32'd1);
      check("single cmp_en off", {31'd0, bus.cmp_en}, 32'd0);
      check("single cmp_a hold", bus.cmp_a, 32'h3F800000);
      cycle(4'b0000, 4'b0000, "single s3");
      check("single busy S3", {31'd0, bus.busy}, 32'd0);
      cycle(4'b0000, 4'b0000, "single after");
      check("resp_data hold", bus.resp_data, 32'd1);

      // Wrap and skip: drive ptr to 3, then only requesters 0 and 2 valid.
      set_req(2, 32'h40A00000, 32'h40400000, 2'b01);
      cycle(4'b0100, 4'b0100, "wrap pre");
      cycle(4'b0101, 4'b0001, "wrap g0");
      cycle(4'b0101, 4'b0100, "wrap g2");
      cycle(4'b0101, 4'b0001, "wrap g0b");
      for (int i = 0; i < 3; i++) cycle(4'b0000, 4'b0000, "wrap drain");

      // Back-to-back ops from requester 2: 3.0 == 3.0.
      set_req(2, 32'h40400000, 32'h40400000, 2'b00);
      for (int i = 0; i < 3; i++) begin
         cycle(4'b0100, 4'b0100, "b2b");
         check("b2b cmp_en", {31'd0, bus.cmp_en}, 32'd1);
      end
      cycle(4'b0000, 4'b0000, "b2b drain");
      check("b2b cmp_en off", {31'd0, bus.cmp_en}, 32'd0);
      for (int i = 0; i < 2; i++) cycle(4'b0000, 4'b0000, "b2b drain");
      check("err clean", {31'd0, bus.err}, 32'd0);

      // Lost result: the unit withholds cmp_ready for one op, the next still answers.
      set_req(1, 32'h40000000, 32'h3F800000, 2'b01);
      set_req(0, 32'h3F800000, 32'h3F800000, 2'b10);
      lose_next = 1'b1;
      cycle(4'b0010, 4'b0010, "lost op");
      cycle(4'b0001, 4'b0001, "after lost");
      for (int i = 0; i < 3; i++) cycle(4'b0000, 4'b0000, "lost drain");
      check("lost err", {31'd0, bus.err}, 32'd1);

      // Unexpected result while idle.
      do_reset(1'b0);
      check("err cleared", {31'd0, bus.err}, 32'd0);
      cycle(4'b0000, 4'b0000, "spur idle");
      spur = 1'b1;
      cycle(4'b0000, 4'b0000, "spur pulse");
      for (int i = 0; i < 2; i++) cycle(4'b0000, 4'b0000, "spur after");
      check("spur err", {31'd0, bus.err}, 32'd1);

      // Reset while an op sits in S2.
      do_reset(1'b0);
      cycle(4'b0010, 4'b0010, "mid pre");
      for (int i = 0; i < 3; i++) cycle(4'b0000, 4'b0000, "mid pre drain");
      cycle(4'b0100, 4'b0100, "mid issue");
      cycle(4'b0000, 4'b0000, "mid s2");
      rstn = 1'b0;
      #1;
      check("mid resp_valid", {28'd0, bus.resp_valid}, 32'd0);
      check("mid busy", {31'd0, bus.busy}, 32'd0);
      check("mid cmp_en", {31'd0, bus.cmp_en}, 32'd0);
      sb.delete();
      pend_en = 1'b0; withhold_cyc = -1;
      @(posedge clk);
      cyc++;
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      cyc++;
      #1;
      apply_model();
      for (int i = 0; i < 3; i++) cycle(4'b0000, 4'b0000, "mid after");
      cycle(4'b1111, 4'b0001, "mid first grant");
      for (int i = 0; i < 3; i++) cycle(4'b0000, 4'b0000, "mid final drain");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/fcmp_sched.md
Name: fcmp_sched

Overview:
- Round-robin scheduler that shares one pipelined FP compare unit (feq/flt/fle family) among N_REQ requesters, e.g. the integer pipe, branch unit and FP-select logic.
- The compare unit has 1-cycle latency. It takes operands and an enable, and returns a 32-bit result word (bit 0 = truth) with a ready pulse.
- This block arbitrates requests, drives the unit's inputs from registers, tags each in-flight op, and routes each result back to its originating requester.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- IDW, 2, tag width; must equal clog2(N_REQ).

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  one-hot grant; the request is accepted in a cycle where req_valid[i] & req_ready[i].
- req_a  in  32*N_REQ  operand A; requester i uses bits [32i+31:32i].
- req_b  in  32*N_REQ  operand B, same slicing.
- req_op  in  2*N_REQ  opcode, slice [2i+1:2i]: 00 feq, 01 flt, 10 fle, 11 reserved (forwarded unchanged).
- resp_valid  out  N_REQ  one-hot, 1-cycle result pulse.
- resp_data  out  32  result word; meaningful only when resp_valid != 0.
- cmp_a  out  32  operand A to the compare unit.
- cmp_b  out  32  operand B to the compare unit.
- cmp_op  out  2  opcode to the compare unit.
- cmp_en  out  1  issue strobe to the compare unit.
- cmp_c  in  32  compare unit result.
- cmp_ready  in  1  compare unit ready, expected exactly 1 cycle after cmp_en.
- busy  out  1  any op in flight (stage S1 or S2 valid).
- err  out  1  sticky protocol error.

Behaviour:
- Reset (rstn=0, async): the following are all cleared to 0.
  - Outputs: req_ready, resp_valid, resp_data, cmp_a, cmp_b, cmp_op, cmp_en, busy, err.
  - Internal state: round-robin pointer ptr, S1/S2 tag valids.
  - Deassertion is sampled at the next clk edge.
- Arbitration (combinational within cycle T):
  - The grant g is the first i in ptr, ptr+1, ..., wrapping mod N_REQ, with req_valid[i]=1.
  - req_ready = onehot(g) if any req_valid, else 0. req_ready never asserts for a requester whose req_valid is 0.
  - No backpressure: the scheduler accepts one request every cycle.
  - On acceptance, ptr <= (g+1) mod N_REQ. If nothing is granted, ptr holds.
- Pipeline, for a request accepted at edge T:
  - S1 (T+1): cmp_a/cmp_b/cmp_op registered from slice g; cmp_en=1; tag1=g; v1=1.
  - S2 (T+2): tag2<=tag1, v2<=v1. cmp_ready is expected high this cycle.
  - S3 (T+3): if v2 & cmp_ready at T+2, then resp_data<=cmp_c and resp_valid<=onehot(tag2) for one cycle.
  - Request-to-response latency is 3 cycles. Throughput is 1 op/cycle, including back-to-back ops from the same requester.
  - With no grant, cmp_en=0 and cmp_a/b/op hold their previous values.
- resp_data holds its last value when resp_valid=0.
- busy = v1 | v2.
- Error handling (err stays 1 until reset):
  - cmp_ready=1 while v2=0 (unexpected result): set err; ignore cmp_c; no resp_valid.
  - v2=1 while cmp_ready=0 (lost result): set err; drop that tag; no resp_valid for it.
  - Pipeline and arbitration continue unaffected.
- Reserved opcode 11 is forwarded unchanged. The scheduler does not interpret opcodes.
- Simultaneous events:
  - A response for requester i and a new grant to requester i in the same cycle are independent; both occur.
  - A request withdrawn (req_valid dropped) before grant is simply not issued.
- Reset mid-operation drops all in-flight ops. No resp_valid is produced for them after reset, and ptr returns to 0.

Test Plan:
- Single op: req 0, a=0x3F800000 (1.0), b=0x40000000 (2.0), op=10 fle. Expect req_ready=0001 at T; cmp_en=1 with cmp_a=0x3F800000 at T+1; resp_valid=0001 and resp_data=0x00000001 at T+3; busy high T+1..T+2.
- Round-robin fairness: all 4 req_valid held high for 8 cycles. Grants must be 0,1,2,3,0,1,2,3. Responses appear in the same order, each 3 cycles after its grant.
- Wrap and skip: ptr=3, req_valid=0101. Grant must go to 0, then ptr=1, then grant to 2. Requesters 1 and 3 are never granted.
- Back-to-back from one requester: req 2 valid for 3 cycles with b=a, a=0x40400000, op=00 feq. Expect three consecutive resp_valid=0100 pulses, each with data=0x00000001; cmp_en high 3 consecutive cycles.
- Protocol errors:
  - Model withholds cmp_ready for one op: err=1, that op gets no response, the next op still responds.
  - Separately, model pulses cmp_ready while idle: err=1, resp_valid stays 0.
- Reset mid-flight: rstn low at T+2 for an op accepted at T. resp_valid, busy and cmp_en must be 0 immediately (async). No response after release; the first grant after release starts from requester 0.
